mgmt_pll_reconfig_ctrl: RTL and testbench

// Sequences the LTPI link PLL for the PHY management FSM. Serves the pll_reconfig / pll_configuration_done handshake.

---
 rtl/mgmt_pll_reconfig_ctrl_if.sv | 26 ++
 rtl/mgmt_pll_reconfig_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mgmt_pll_reconfig_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mgmt_pll_reconfig_ctrl_if.sv
// rtl/mgmt_pll_reconfig_ctrl_if.sv - PLL reconfig management port bundle
interface mgmt_pll_reconfig_ctrl_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] mgmt_address;
   logic              mgmt_write;
   logic [31:0]       mgmt_writedata;
   logic              mgmt_waitrequest;
   logic              reconfig_busy;

   modport master (
      output mgmt_address,
      output mgmt_write,
      output mgmt_writedata,
      input  mgmt_waitrequest,
      input  reconfig_busy
   );

   modport slave (
      input  mgmt_address,
      input  mgmt_write,
      input  mgmt_writedata,
      output mgmt_waitrequest,
      output reconfig_busy
   );
endinterface

// File: rtl/mgmt_pll_reconfig_ctrl.sv
// rtl/mgmt_pll_reconfig_ctrl.sv - LTPI link PLL reprogramming and lock qualification sequencer
module mgmt_pll_reconfig_ctrl #(
   parameter int                          ADDR_W              = 6,
   parameter int                          CFG_WORDS           = 3,
   parameter logic [ADDR_W-1:0]           CFG_BASE_ADDR       = 6'h04,
   parameter logic [ADDR_W-1:0]           START_ADDR          = 6'h02,
   parameter logic [16*CFG_WORDS*32-1:0]  CFG_TABLE           = '0,
   parameter logic [3:0]                  BASE_SPEED          = 4'd0,
   parameter int                          RST_HOLD_CYCLES     = 16,
   parameter int                          LOCK_STABLE_CYCLES  = 64,
   parameter int                          LOCK_TIMEOUT_CYCLES = 60000,
   parameter int                          MAX_RETRY           = 2
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    pll_reconfig_i,
   input  logic                    base_speed_req_i,
   input  logic [3:0]              operational_speed_i,
   output logic                    pll_configuration_done_o,
   output logic                    change_freq_st_o,
   output logic                    pll_reconfig_err_o,
   output logic                    pll_areset_o,
   input  logic                    pll_locked_i,
   mgmt_pll_reconfig_ctrl_if.master mgmt
);

   // One timer serves the reset hold and both timeouts, so it is sized for the larger.
   localparam int TMR_MAX = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int LOCK_W  = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int WORD_W  = $clog2(CFG_WORDS + 1);
   localparam int RETRY_W = $clog2(MAX_RETRY + 2);

   typedef enum logic [2:0] {
      IDLE, ASSERT_RST, WRITE_CFG, WRITE_START, WAIT_BUSY, WAIT_LOCK, DONE, ERR
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         speed_q, speed_d;
   logic               base_q, base_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [LOCK_W-1:0]  lock_q, lock_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               done_q, done_d;
   logic               chg_q, chg_d;
   logic               err_q, err_d;
   logic               areset_q, areset_d;

   // State and status registers; the PLL is held in reset whenever the block is reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= IDLE;
         speed_q  <= '0;
         base_q   <= 1'b0;
         tmr_q    <= '0;
         lock_q   <= '0;
         word_q   <= '0;
         retry_q  <= '0;
         done_q   <= 1'b0;
         chg_q    <= 1'b0;
         err_q    <= 1'b0;
         areset_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         speed_q  <= speed_d;
         base_q   <= base_d;
         tmr_q    <= tmr_d;
         lock_q   <= lock_d;
         word_q   <= word_d;
         retry_q  <= retry_d;
         done_q   <= done_d;
         chg_q    <= chg_d;
         err_q    <= err_d;
         areset_q <= areset_d;
      end
   end

   // Sequencing: once accepted a request always runs to DONE or ERR, never half-programmed.
   always_comb begin
      state_d  = state_q;
      speed_d  = speed_q;
      base_d   = base_q;
      tmr_d    = tmr_q;
      lock_d   = lock_q;
      word_d   = word_q;
      retry_d  = retry_q;
      done_d   = done_q;
      chg_d    = chg_q;
      err_d    = err_q;
      areset_d = areset_q;
      case (state_q)
         IDLE: begin
            if (pll_reconfig_i) begin
               speed_d  = base_speed_req_i ? BASE_SPEED : operational_speed_i;
               base_d   = base_speed_req_i;
               err_d    = 1'b0;
               retry_d  = '0;
               if (base_speed_req_i) chg_d = 1'b0;
               areset_d = 1'b1;
               tmr_d    = '0;
               state_d  = ASSERT_RST;
            end
         end
         ASSERT_RST: begin
            if (tmr_q == TMR_W'(RST_HOLD_CYCLES - 1)) begin
               tmr_d   = '0;
               word_d  = '0;
               state_d = WRITE_CFG;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WRITE_CFG: begin
            if (!mgmt.mgmt_waitrequest) begin
               if (word_q == WORD_W'(CFG_WORDS - 1)) begin
                  word_d  = '0;
                  state_d = WRITE_START;
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
         end
         WRITE_START: begin
            if (!mgmt.mgmt_waitrequest) begin
               tmr_d   = '0;
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            // reconfig_busy may lag the start write, so the first two cycles are not trusted.
            if (tmr_q >= TMR_W'(2) && !mgmt.reconfig_busy) begin
               areset_d = 1'b0;
               tmr_d    = '0;
               lock_d   = '0;
               state_d  = WAIT_LOCK;
            end else if (tmr_q == TMR_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
               err_d    = 1'b1;
               areset_d = 1'b1;
               chg_d    = 1'b0;
               done_d   = 1'b0;
               state_d  = ERR;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (pll_locked_i && lock_q == LOCK_W'(LOCK_STABLE_CYCLES - 1)) begin
               done_d  = pll_reconfig_i;
               chg_d   = !base_q;
               state_d = DONE;
            end else if (tmr_q == TMR_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
               areset_d = 1'b1;
               tmr_d    = '0;
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ASSERT_RST;
               end else begin
                  err_d   = 1'b1;
                  chg_d   = 1'b0;
                  done_d  = 1'b0;
                  state_d = ERR;
               end
            end else begin
               tmr_d  = tmr_q + 1'b1;
               lock_d = pll_locked_i ? lock_q + 1'b1 : '0;
            end
         end
         DONE: begin
            if (!pll_reconfig_i) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         ERR: begin
            err_d    = 1'b1;
            areset_d = 1'b1;
            chg_d    = 1'b0;
            done_d   = 1'b0;
            if (!pll_reconfig_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Management port is decoded from state so an async reset drops the write strobe at once.
   always_comb begin
      int idx;
      idx                 = (int'(speed_q) * CFG_WORDS + int'(word_q)) * 32;
      mgmt.mgmt_write     = 1'b0;
      mgmt.mgmt_address   = '0;
      mgmt.mgmt_writedata = '0;
      if (state_q == WRITE_CFG) begin
         mgmt.mgmt_write     = 1'b1;
         mgmt.mgmt_address   = CFG_BASE_ADDR + ADDR_W'(word_q);
         mgmt.mgmt_writedata = CFG_TABLE[idx +: 32];
      end else if (state_q == WRITE_START) begin
         mgmt.mgmt_write     = 1'b1;
         mgmt.mgmt_address   = START_ADDR;
         mgmt.mgmt_writedata = 32'h1;
      end
   end

   assign pll_configuration_done_o = done_q;
   assign change_freq_st_o         = chg_q;
   assign pll_reconfig_err_o       = err_q;
   assign pll_areset_o             = areset_q;

endmodule

// File: tb/tb_mgmt_pll_reconfig_ctrl.sv
// tb/tb_mgmt_pll_reconfig_ctrl.sv - directed self-checking bench for mgmt_pll_reconfig_ctrl
module tb_mgmt_pll_reconfig_ctrl;

   function automatic logic [31:0] cfg_word(input int s, input int i);
      return {16'hC0DE, 4'(s), 4'h0, 8'(i)};
   endfunction

   function automatic logic [16*3*32-1:0] mk_tbl();
      logic [16*3*32-1:0] t;
      t = '0;
      for (int s = 0; s < 16; s++)
         for (int i = 0; i < 3; i++)
            t[(s*3+i)*32 +: 32] = cfg_word(s, i);
      return t;
   endfunction

   localparam logic [16*3*32-1:0] TBL = mk_tbl();

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_reconfig = 1'b0;
   logic       base_speed_req = 1'b0;
   logic [3:0] operational_speed = 4'd0;
   logic       done, chg, err, areset;
   logic       pll_locked = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   mgmt_pll_reconfig_ctrl_if #(.ADDR_W(6)) mif ();

   mgmt_pll_reconfig_ctrl #(
      .ADDR_W(6), .CFG_WORDS(3), .CFG_BASE_ADDR(6'h04), .START_ADDR(6'h02),
      .CFG_TABLE(TBL), .BASE_SPEED(4'd0), .RST_HOLD_CYCLES(16),
      .LOCK_STABLE_CYCLES(64), .LOCK_TIMEOUT_CYCLES(300), .MAX_RETRY(2)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .pll_reconfig_i(pll_reconfig), .base_speed_req_i(base_speed_req),
      .operational_speed_i(operational_speed),
      .pll_configuration_done_o(done), .change_freq_st_o(chg),
      .pll_reconfig_err_o(err), .pll_areset_o(areset),
      .pll_locked_i(pll_locked), .mgmt(mif.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reconfig port model: optional stall on one address, busy pulse after start, write log.
   logic [37:0] wr_q[$];
   int          stall_left = 0;
   logic [5:0]  stall_addr = 6'h3f;
   int          busy_left  = 0;
   int          n_start    = 0;
   logic        holding    = 1'b0;
   logic [5:0]  hold_a;
   logic [31:0] hold_d;

   initial begin
      mif.mgmt_waitrequest = 1'b0;
      mif.reconfig_busy    = 1'b0;
   end

   always @(negedge clk) begin
      mif.reconfig_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (holding) begin
         check("stall_addr", 32'(mif.mgmt_address), 32'(hold_a));
         check("stall_data", mif.mgmt_writedata, hold_d);
      end
      if (mif.mgmt_write && mif.mgmt_address == stall_addr && stall_left > 0) begin
         if (!holding) begin
            holding = 1'b1;
            hold_a  = mif.mgmt_address;
            hold_d  = mif.mgmt_writedata;
         end
         mif.mgmt_waitrequest = 1'b1;
         stall_left--;
      end else begin
         holding = 1'b0;
         mif.mgmt_waitrequest = 1'b0;
      end
      if (mif.mgmt_write && !mif.mgmt_waitrequest) begin
         wr_q.push_back({mif.mgmt_address, mif.mgmt_writedata});
         if (mif.mgmt_address == 6'h02) begin
            busy_left = 3;
            n_start++;
         end
      end
   end

   task automatic request(input logic base, input logic [3:0] spd);
      wr_q.delete();
      base_speed_req    = base;
      operational_speed = spd;
      pll_reconfig      = 1'b1;
   endtask

   task automatic wait_level(input string tag, input logic want, input int budget, input int which);
      int c = 0;
      logic v;
      v = (which == 0) ? areset : (which == 1) ? done : err;
      while (v !== want && c < budget) begin
         @(negedge clk);
         c++;
         v = (which == 0) ? areset : (which == 1) ? done : err;
      end
      if (v !== want) check(tag, 32'(v), 32'(want));
   endtask

   task automatic check_writes(input string tag, input int spd);
      check({tag, "_nwr"}, wr_q.size(), 4);
      if (wr_q.size() == 4) begin
         for (int i = 0; i < 3; i++) begin
            check({tag, "_addr"}, 32'(wr_q[i][37:32]), 32'(6'h04 + i));
            check({tag, "_data"}, wr_q[i][31:0], cfg_word(spd, i));
         end
         check({tag, "_start_addr"}, 32'(wr_q[3][37:32]), 32'h02);
         check({tag, "_start_data"}, wr_q[3][31:0], 32'h1);
      end
   endtask

   task automatic release_req();
      pll_reconfig = 1'b0;
      @(negedge clk);
      check("done_drop", 32'(done), 0);
      @(negedge clk);
   endtask

   initial begin
      int c;
      repeat (3) @(negedge clk);
      check("rst_areset", 32'(areset), 1);
      check("rst_done", 32'(done), 0);
      check("rst_chg", 32'(chg), 0);
      check("rst_err", 32'(err), 0);
      check("rst_write", 32'(mif.mgmt_write), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Base request, lock already present
      pll_locked = 1'b1;
      request(1'b1, 4'd9);
      c = 0;
      @(negedge clk);
      while (!mif.mgmt_write && c < 100) begin
         check("hold_areset", 32'(areset), 1);
         c++;
         @(negedge clk);
      end
      check("hold_cycles", c, 16);
      wait_level("areset_fall", 1'b0, 100, 0);
      c = 0;
      while (!done && c < 200) begin @(negedge clk); c++; end
      check("lock_cycles", c, 64);
      check_writes("base", 0);
      check("base_chg", 32'(chg), 0);
      release_req();

      // Operational speed 3, then a base request clears change_freq_st at accept
      request(1'b0, 4'd3);
      wait_level("op_done", 1'b1, 500, 1);
      check_writes("op3", 3);
      check("op_chg", 32'(chg), 1);
      release_req();
      check("op_chg_held", 32'(chg), 1);
      request(1'b1, 4'd3);
      @(negedge clk);
      check("base_accept_chg", 32'(chg), 0);
      wait_level("base2_done", 1'b1, 500, 1);
      check("base2_chg", 32'(chg), 0);
      release_req();

      // Five-cycle stall on word 1
      stall_addr = 6'h05;
      stall_left = 5;
      request(1'b0, 4'd7);
      wait_level("stall_done", 1'b1, 500, 1);
      check("stall_used", stall_left, 0);
      check_writes("stall", 7);
      release_req();
      stall_addr = 6'h3f;

      // Lock glitch at count 30
      request(1'b1, 4'd0);
      wait_level("gl_areset_rise", 1'b1, 10, 0);
      wait_level("gl_areset_fall", 1'b0, 100, 0);
      repeat (30) @(negedge clk);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      c = 0;
      while (!done && c < 200) begin @(negedge clk); c++; end
      check("glitch_cycles", c, 64);
      release_req();

      // Lock never comes: three attempts then error
      pll_locked = 1'b0;
      n_start = 0;
      request(1'b0, 4'd2);
      wait_level("err_set", 1'b1, 3000, 2);
      check("err_starts", n_start, 3);
      check("err_areset", 32'(areset), 1);
      check("err_done", 32'(done), 0);
      check("err_chg", 32'(chg), 0);
      repeat (3) @(negedge clk);
      check("err_sticky", 32'(err), 1);
      pll_reconfig = 1'b0;
      repeat (2) @(negedge clk);
      check("err_idle_kept", 32'(err), 1);
      pll_locked = 1'b1;
      request(1'b0, 4'd2);
      @(negedge clk);
      check("err_clear", 32'(err), 0);
      wait_level("err_recover", 1'b1, 500, 1);
      check("recover_chg", 32'(chg), 1);
      release_req();

      // Async reset while writing word 2
      request(1'b0, 4'd5);
      c = 0;
      while (!(mif.mgmt_write && mif.mgmt_address == 6'h06) && c < 100) begin @(negedge clk); c++; end
      check("reach_word2", 32'(mif.mgmt_address), 32'h06);
      #1 reset_n = 1'b0;
      #1;
      check("arst_write", 32'(mif.mgmt_write), 0);
      check("arst_areset", 32'(areset), 1);
      @(negedge clk);
      wr_q.delete();
      reset_n = 1'b1;
      c = 0;
      while (wr_q.size() == 0 && c < 100) begin @(negedge clk); c++; end
      check("restart_nwr", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) begin
         check("restart_addr", 32'(wr_q[0][37:32]), 32'h04);
         check("restart_data", wr_q[0][31:0], cfg_word(5, 0));
      end
      wait_level("restart_done", 1'b1, 500, 1);
      check_writes("restart", 5);
      release_req();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
